// File: rtl/pbl_pkg.sv
// Shared definitions for the instruction-fetch slice: default widths,
// the reset fetch address and the fetch-unit state encoding.
package pbl_pkg;

    localparam int          LARGURA_PADRAO    = 32;
    localparam int          INCREMENTO_PADRAO = 4;
    localparam logic [31:0] PC_RESET_PADRAO   = 32'h0000_0000;

    // INICIO   : idle after reset, no request yet
    // BUSCA    : request outstanding for mem_endereco
    // DESCARTA : request outstanding, but its word belongs to a squashed path
    // ENTREGA  : fetched word held for decode
    typedef enum logic [1:0] {
        INICIO   = 2'd0,
        BUSCA    = 2'd1,
        DESCARTA = 2'd2,
        ENTREGA  = 2'd3
    } estado_t;

endpackage

// File: rtl/contador_pc.sv
// Program counter: holds the next fetch address, loads a redirect target
// or steps sequentially (wrapping modulo 2^LARGURA).
module contador_pc
    import pbl_pkg::*;
#(
    parameter int                 LARGURA    = LARGURA_PADRAO,
    parameter logic [LARGURA-1:0] PC_RESET   = LARGURA'(PC_RESET_PADRAO),
    parameter int                 INCREMENTO = INCREMENTO_PADRAO
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               carregar,
    input  logic [LARGURA-1:0] alvo,
    input  logic               incrementar,
    output logic [LARGURA-1:0] pc
);

    logic [LARGURA-1:0] pc_d;
    logic [LARGURA-1:0] pc_q;

    // Next PC: a load takes priority over the sequential step; the sum is
    // truncated to LARGURA bits so the last word wraps to address zero.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        pc_d = pc_q;
        if (carregar) begin
            pc_d = alvo;
        end else if (incrementar) begin
            pc_d = pc_q + LARGURA'(INCREMENTO);
        end
    end

    // PC register with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!reset) begin
            pc_q <= PC_RESET;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/unidade_busca.sv
// Instruction-fetch unit: issues one memory request per instruction, holds
// the fetched word for decode over valid/ready, and handles taken-branch
// redirects by squashing held words and discarding in-flight fetches.
module unidade_busca
    import pbl_pkg::*;
#(
    parameter int                 LARGURA    = LARGURA_PADRAO,
    parameter logic [LARGURA-1:0] PC_RESET   = LARGURA'(PC_RESET_PADRAO),
    parameter int                 INCREMENTO = INCREMENTO_PADRAO
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               desvio_valido,
    input  logic [LARGURA-1:0] desvio_alvo,
    output logic               mem_req,
    output logic [LARGURA-1:0] mem_endereco,
    input  logic               mem_ack,
    input  logic [LARGURA-1:0] mem_dado,
    output logic               instr_valida,
    input  logic               instr_pronta,
    output logic [LARGURA-1:0] instr,
    output logic [LARGURA-1:0] instr_pc
);

    estado_t            estado_d, estado_q;
    logic [LARGURA-1:0] mem_endereco_d, mem_endereco_q;
    logic [LARGURA-1:0] instr_d, instr_q;
    logic [LARGURA-1:0] instr_pc_d, instr_pc_q;
    logic               mem_req_d, mem_req_q;
    logic               entrega_d, entrega_q;

    logic               pc_carregar;
    logic               pc_incrementar;
    logic [LARGURA-1:0] pc;
    logic [LARGURA-1:0] alvo;

    // Branch targets are always word-aligned; the low two bits are dropped.
    assign alvo = desvio_alvo & ~LARGURA'(3);

    contador_pc #(
        .LARGURA    (LARGURA),
        .PC_RESET   (PC_RESET),
        .INCREMENTO (INCREMENTO)
    ) u_contador_pc (
        .clock       (clock),
        .reset       (reset),
        .carregar    (pc_carregar),
        .alvo        (alvo),
        .incrementar (pc_incrementar),
        .pc          (pc)
    );

    // Next-state and datapath control for the fetch FSM. In BUSCA the PC
    // always equals mem_endereco, so stepping the PC yields the next address.
    always_comb begin
        estado_d       = estado_q;
        mem_endereco_d = mem_endereco_q;
        instr_d        = instr_q;
        instr_pc_d     = instr_pc_q;
        pc_carregar    = 1'b0;
        pc_incrementar = 1'b0;

        unique case (estado_q)
            INICIO: begin
                mem_endereco_d = pc;
                estado_d       = BUSCA;
            end
            BUSCA: begin
                if (mem_ack && desvio_valido) begin
                    // Word belongs to the squashed path: drop it and
                    // re-request at the target straight away.
                    pc_carregar    = 1'b1;
                    mem_endereco_d = alvo;
                end else if (mem_ack) begin
                    instr_d        = mem_dado;
                    instr_pc_d     = mem_endereco_q;
                    pc_incrementar = 1'b1;
                    estado_d       = ENTREGA;
                end else if (desvio_valido) begin
                    // The request cannot be abandoned; remember the target
                    // and wait for the stale response.
                    pc_carregar = 1'b1;
                    estado_d    = DESCARTA;
                end
            end
            DESCARTA: begin
                if (desvio_valido) begin
                    pc_carregar = 1'b1;
                end
                if (mem_ack) begin
                    mem_endereco_d = desvio_valido ? alvo : pc;
                    estado_d       = BUSCA;
                end
            end
            ENTREGA: begin
                if (desvio_valido) begin
                    pc_carregar    = 1'b1;
                    mem_endereco_d = alvo;
                    estado_d       = BUSCA;
                end else if (instr_pronta) begin
                    mem_endereco_d = pc;
                    estado_d       = BUSCA;
                end
            end
            default: begin
                estado_d = INICIO;
            end
        endcase

        mem_req_d = (estado_d == BUSCA) || (estado_d == DESCARTA);
        entrega_d = (estado_d == ENTREGA);
    end

    // FSM state, fetch address, held instruction and registered status flags.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q       <= INICIO;
            mem_endereco_q <= PC_RESET;
            instr_q        <= '0;
            instr_pc_q     <= '0;
            mem_req_q      <= 1'b0;
            entrega_q      <= 1'b0;
        end else begin
            estado_q       <= estado_d;
            mem_endereco_q <= mem_endereco_d;
            instr_q        <= instr_d;
            instr_pc_q     <= instr_pc_d;
            mem_req_q      <= mem_req_d;
            entrega_q      <= entrega_d;
        end
    end

    assign mem_req      = mem_req_q;
    assign mem_endereco = mem_endereco_q;
    assign instr        = instr_q;
    assign instr_pc     = instr_pc_q;
    // A redirect in the same cycle squashes the held word before decode sees it.
    assign instr_valida = entrega_q && !desvio_valido;

endmodule

// File: tb/tb_unidade_busca.sv
// Directed bench for unidade_busca: a latency-programmable memory responder
// plus per-scenario tasks with hand-computed expectations.
module tb_unidade_busca;

    localparam logic [31:0] CHAVE = 32'hA5A5_A5A5;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        desvio_valido = 1'b0;
    logic [31:0] desvio_alvo = '0;
    logic        mem_req;
    logic [31:0] mem_endereco;
    logic        mem_ack;
    logic [31:0] mem_dado;
    logic        instr_valida;
    logic        instr_pronta = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    int total = 0;
    int bad   = 0;
    int lat   = 0;
    int espera = 0;

    logic [31:0] reqs[$];
    logic [31:0] xpc[$];
    logic [31:0] xins[$];

    unidade_busca dut (
        .clock         (clock),
        .reset         (reset),
        .desvio_valido (desvio_valido),
        .desvio_alvo   (desvio_alvo),
        .mem_req       (mem_req),
        .mem_endereco  (mem_endereco),
        .mem_ack       (mem_ack),
        .mem_dado      (mem_dado),
        .instr_valida  (instr_valida),
        .instr_pronta  (instr_pronta),
        .instr         (instr),
        .instr_pc      (instr_pc)
    );

    always #5 clock = ~clock;

    // Memory: acknowledges after 'lat' waiting cycles, returns address ^ CHAVE.
    assign mem_ack  = mem_req && (espera >= lat);
    assign mem_dado = mem_endereco ^ CHAVE;

    always @(posedge clock or negedge reset) begin
        if (!reset) espera <= 0;
        else if (mem_req && !mem_ack) espera <= espera + 1;
        else espera <= 0;
    end

    // Log completed fetches and accepted instructions.
    always @(posedge clock) begin
        if (reset && mem_req && mem_ack) reqs.push_back(mem_endereco);
        if (reset && instr_valida && instr_pronta) begin
            xpc.push_back(instr_pc);
            xins.push_back(instr);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", mem_req); end
        total++; if (instr_valida !== 1'b0) begin bad++; $display("FAIL rst_valida got=%b exp=0", instr_valida); end
        total++; if (mem_endereco !== 32'h0) begin bad++; $display("FAIL rst_end got=%h exp=0", mem_endereco); end
        total++; if (instr !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h exp=0", instr); end
        total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL rst_instr_pc got=%h exp=0", instr_pc); end
    endtask

    task automatic test_sequential();
        logic [31:0] a;
        lat = 0;
        instr_pronta = 1'b1;
        reset = 1'b1;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL seq_no_req_first got=%b exp=0", mem_req); end
        for (int k = 0; k < 3; k++) begin
            a = 32'(4 * k);
            tick();
            total++; if (mem_req !== 1'b1 || mem_endereco !== a || instr_valida !== 1'b0) begin
                bad++; $display("FAIL seq_req%0d got req=%b end=%h val=%b exp req=1 end=%h val=0", k, mem_req, mem_endereco, instr_valida, a);
            end
            tick();
            total++; if (instr_valida !== 1'b1 || instr_pc !== a || instr !== (a ^ CHAVE)) begin
                bad++; $display("FAIL seq_instr%0d got val=%b pc=%h ins=%h exp val=1 pc=%h ins=%h", k, instr_valida, instr_pc, instr, a, a ^ CHAVE);
            end
        end
        instr_pronta = 1'b0;
        total++; if (reqs.size() != 3 || reqs[0] !== 32'h0 || reqs[1] !== 32'h4 || reqs[2] !== 32'h8) begin
            bad++; $display("FAIL seq_reqs got n=%0d exp n=3 (0,4,8)", reqs.size());
        end
        total++; if (xpc.size() != 2 || xpc[0] !== 32'h0 || xpc[1] !== 32'h4) begin
            bad++; $display("FAIL seq_xfers got n=%0d exp n=2 (0,4)", xpc.size());
        end
    endtask

    task automatic test_stall();
        lat = 3;
        instr_pronta = 1'b1;          // accept held word 8
        for (int k = 0; k < 4; k++) begin
            tick();
            total++; if (mem_req !== 1'b1 || mem_endereco !== 32'hC || mem_ack !== (k == 3)) begin
                bad++; $display("FAIL stall_wait%0d got req=%b end=%h ack=%b exp req=1 end=0000000c", k, mem_req, mem_endereco, mem_ack);
            end
            instr_pronta = 1'b0;
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            total++; if (instr_valida !== 1'b1 || instr_pc !== 32'hC || instr !== (32'hC ^ CHAVE)) begin
                bad++; $display("FAIL stall_hold%0d got val=%b pc=%h ins=%h exp val=1 pc=0000000c", k, instr_valida, instr_pc, instr);
            end
        end
        instr_pronta = 1'b1;
        tick();
        total++; if (mem_endereco !== 32'h10 || mem_req !== 1'b1) begin
            bad++; $display("FAIL stall_next got end=%h req=%b exp end=00000010 req=1", mem_endereco, mem_req);
        end
        total++; if (reqs.size() != 4 || reqs[3] !== 32'hC || xpc.size() != 4 || xpc[2] !== 32'h8 || xpc[3] !== 32'hC) begin
            bad++; $display("FAIL stall_order got reqs=%0d xfers=%0d exp 4/4", reqs.size(), xpc.size());
        end
    endtask

    task automatic test_redirect_busca();
        int n;
        n = xpc.size();
        lat = 2;
        desvio_valido = 1'b1;
        desvio_alvo = 32'h0000_0103;
        #1;
        total++; if (instr_valida !== 1'b0 || mem_ack !== 1'b0) begin
            bad++; $display("FAIL rb_setup got val=%b ack=%b exp 0/0", instr_valida, mem_ack);
        end
        tick();
        desvio_valido = 1'b0;
        desvio_alvo = '0;
        total++; if (mem_req !== 1'b1 || mem_endereco !== 32'h10) begin
            bad++; $display("FAIL rb_stale_hold got req=%b end=%h exp req=1 end=00000010", mem_req, mem_endereco);
        end
        tick();
        total++; if (mem_ack !== 1'b1 || mem_endereco !== 32'h10 || instr_valida !== 1'b0) begin
            bad++; $display("FAIL rb_stale_ack got ack=%b end=%h val=%b exp ack=1 end=00000010 val=0", mem_ack, mem_endereco, instr_valida);
        end
        tick();
        total++; if (mem_req !== 1'b1 || mem_endereco !== 32'h100 || instr_valida !== 1'b0) begin
            bad++; $display("FAIL rb_target got req=%b end=%h val=%b exp req=1 end=00000100 val=0", mem_req, mem_endereco, instr_valida);
        end
        lat = 0;
        tick();
        total++; if (instr_valida !== 1'b1 || instr_pc !== 32'h100 || instr !== (32'h100 ^ CHAVE) || xpc.size() != n) begin
            bad++; $display("FAIL rb_deliver got val=%b pc=%h xfers=%0d exp val=1 pc=00000100 xfers=%0d", instr_valida, instr_pc, xpc.size(), n);
        end
    endtask

    task automatic test_redirect_entrega();
        int n;
        n = xpc.size();
        desvio_valido = 1'b1;
        desvio_alvo = 32'h40;
        #1;
        total++; if (instr_valida !== 1'b0) begin
            bad++; $display("FAIL re_squash got val=%b exp 0", instr_valida);
        end
        tick();
        desvio_valido = 1'b0;
        total++; if (mem_req !== 1'b1 || mem_endereco !== 32'h40 || xpc.size() != n) begin
            bad++; $display("FAIL re_target got req=%b end=%h xfers=%0d exp req=1 end=00000040 xfers=%0d", mem_req, mem_endereco, xpc.size(), n);
        end
        tick();
        total++; if (instr_valida !== 1'b1 || instr_pc !== 32'h40) begin
            bad++; $display("FAIL re_deliver got val=%b pc=%h exp val=1 pc=00000040", instr_valida, instr_pc);
        end
    endtask

    task automatic test_wrap();
        desvio_valido = 1'b1;
        desvio_alvo = 32'hFFFF_FFFE;  // low bits must be ignored
        tick();
        desvio_valido = 1'b0;
        total++; if (mem_endereco !== 32'hFFFF_FFFC) begin
            bad++; $display("FAIL wrap_align got end=%h exp fffffffc", mem_endereco);
        end
        tick();
        total++; if (instr_pc !== 32'hFFFF_FFFC || instr_valida !== 1'b1) begin
            bad++; $display("FAIL wrap_top got pc=%h val=%b exp pc=fffffffc val=1", instr_pc, instr_valida);
        end
        tick();
        total++; if (mem_endereco !== 32'h0 || mem_req !== 1'b1) begin
            bad++; $display("FAIL wrap_zero got end=%h req=%b exp end=00000000 req=1", mem_endereco, mem_req);
        end
        tick();
        total++; if (instr_pc !== 32'h0 || instr_valida !== 1'b1) begin
            bad++; $display("FAIL wrap_deliver got pc=%h val=%b exp pc=00000000 val=1", instr_pc, instr_valida);
        end
    endtask

    task automatic test_redirect_with_ack();
        int n;
        tick();                        // BUSCA at 4 with immediate ack
        n = xpc.size();
        desvio_valido = 1'b1;
        desvio_alvo = 32'h200;
        #1;
        total++; if (mem_ack !== 1'b1 || mem_endereco !== 32'h4 || instr_valida !== 1'b0) begin
            bad++; $display("FAIL rwa_setup got ack=%b end=%h val=%b exp ack=1 end=00000004 val=0", mem_ack, mem_endereco, instr_valida);
        end
        tick();
        desvio_valido = 1'b0;
        total++; if (mem_req !== 1'b1 || mem_endereco !== 32'h200 || instr_valida !== 1'b0) begin
            bad++; $display("FAIL rwa_target got req=%b end=%h val=%b exp req=1 end=00000200 val=0", mem_req, mem_endereco, instr_valida);
        end
        tick();
        total++; if (instr_valida !== 1'b1 || instr_pc !== 32'h200 || xpc.size() != n) begin
            bad++; $display("FAIL rwa_deliver got val=%b pc=%h xfers=%0d exp val=1 pc=00000200 xfers=%0d", instr_valida, instr_pc, xpc.size(), n);
        end
    endtask

    task automatic test_reset_descarta();
        lat = 3;
        tick();                        // BUSCA at 0x204, waiting
        desvio_valido = 1'b1;
        desvio_alvo = 32'h300;
        tick();                        // now DESCARTA
        desvio_valido = 1'b0;
        total++; if (mem_req !== 1'b1 || mem_endereco !== 32'h204) begin
            bad++; $display("FAIL rd_setup got req=%b end=%h exp req=1 end=00000204", mem_req, mem_endereco);
        end
        reset = 1'b0;
        #1;
        total++; if (mem_req !== 1'b0 || instr_valida !== 1'b0 || mem_endereco !== 32'h0 || instr !== 32'h0 || instr_pc !== 32'h0) begin
            bad++; $display("FAIL rd_async got req=%b val=%b end=%h ins=%h pc=%h exp all zero", mem_req, instr_valida, mem_endereco, instr, instr_pc);
        end
        tick();
        lat = 0;
        reset = 1'b1;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rd_release got req=%b exp 0", mem_req); end
        tick();
        total++; if (mem_req !== 1'b1 || mem_endereco !== 32'h0) begin
            bad++; $display("FAIL rd_restart got req=%b end=%h exp req=1 end=00000000", mem_req, mem_endereco);
        end
        tick();
        total++; if (instr_valida !== 1'b1 || instr_pc !== 32'h0 || instr !== CHAVE) begin
            bad++; $display("FAIL rd_deliver got val=%b pc=%h ins=%h exp val=1 pc=00000000 ins=%h", instr_valida, instr_pc, instr, CHAVE);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_busca();
        test_redirect_entrega();
        test_wrap();
        test_redirect_with_ack();
        test_reset_descarta();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/unidade_busca.md
# unidade_busca

Instruction-fetch unit that owns the program counter and sits directly downstream of the branch-select 2:1 mux (32-bit `saida` feeds `desvio_alvo`). Issues one request per instruction to instruction memory, holds each fetched word in an output register, and hands it to decode over a valid/ready handshake. Taken branches redirect the PC, squash held instructions and discard any in-flight fetch.

## Interface
- `LARGURA`, 32: address/data width
- `PC_RESET`, 32'h0000_0000: first fetch address after reset
- `INCREMENTO`, 4: sequential PC step
---
- `clock`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-low
- `desvio_valido`  in  1  taken-branch redirect, one-cycle pulse
- `desvio_alvo`  in  LARGURA  redirect target (from branch mux `saida`)
- `mem_req`  out  1  fetch request
- `mem_endereco`  out  LARGURA  fetch address, registered
- `mem_ack`  in  1  fetch complete, `mem_dado` valid this cycle; may assert in the same cycle as `mem_req`
- `mem_dado`  in  LARGURA  fetched word
- `instr_valida`  out  1  `instr`/`instr_pc` valid
- `instr_pronta`  in  1  decode accepts
- `instr`  out  LARGURA  held instruction word
- `instr_pc`  out  LARGURA  address of `instr`

## Operation
- Registers: `pc` (next fetch address), `mem_endereco`, `instr`, `instr_pc`, FSM state.
- `desvio_alvo[1:0]` ignored; target forced word-aligned.
- `pc + INCREMENTO` wraps modulo 2^LARGURA (32'hFFFF_FFFC -> 0).
- FSM states:
  - INICIO: reset state, `mem_req`=0. Next cycle -> BUSCA, `mem_endereco` <= `pc`.
  - BUSCA: `mem_req`=1. On `mem_ack`: `instr`<=`mem_dado`, `instr_pc`<=`mem_endereco`, `pc`<=`mem_endereco`+INCREMENTO, -> ENTREGA. On `desvio_valido` without ack: `pc`<=alvo, -> DESCARTA. On `desvio_valido` with `mem_ack`: word dropped, `pc`/`mem_endereco`<=alvo, stay BUSCA.
  - DESCARTA: `mem_req`=1, `mem_endereco` held at the stale address until ack. On `mem_ack`: word dropped, `mem_endereco`<=`pc`, -> BUSCA. Further `desvio_valido` here: `pc`<=newest alvo.
  - ENTREGA: `instr_valida` = !`desvio_valido`. On `instr_pronta` (no redirect): `mem_endereco`<=`pc`, -> BUSCA. On `desvio_valido`: instruction squashed (no transfer even if `instr_pronta`=1), `pc`/`mem_endereco`<=alvo, -> BUSCA.
- `mem_endereco` and `mem_req` stable from request until ack; no request is ever abandoned.
- `instr`, `instr_pc` stable while `instr_valida`=1 and `instr_pronta`=0.

## Timing
- Reset (async, any state, including mid-fetch): state INICIO, `pc`=`mem_endereco`=PC_RESET, `mem_req`=0, `instr_valida`=0, `instr`=0, `instr_pc`=0. Outstanding memory response after reset is the memory's responsibility.
- First `mem_req` one cycle after `reset` deasserts.
- `mem_ack` in cycle n -> `instr_valida`=1 in n+1.
- Best case (zero-wait memory, decode always ready): one instruction per 2 cycles.
- Redirect -> `mem_req` on alvo: next cycle from BUSCA-with-ack or ENTREGA; from BUSCA-without-ack, one cycle after the stale ack.
- Only combinational path: `desvio_valido` -> `instr_valida`.

## Structure
- Shared package `pbl_pkg`: `LARGURA` default, `INCREMENTO`, `PC_RESET`, FSM state encoding (INICIO, BUSCA, DESCARTA, ENTREGA).
- One sub-module: `contador_pc` — `pc` register with async active-low reset, load (alvo) and increment-with-wrap.

## Test plan
- Reset release, zero-wait memory returning `mem_endereco`^32'hA5A5_A5A5, `instr_pronta`=1 -> requests at 0,4,8; `instr_pc` 0,4,8 on every other cycle, first `instr_valida` 2 cycles after reset release.
- Memory ack delayed 3 cycles, decode stalls 2 cycles -> `mem_endereco` stable during wait; `instr`/`instr_pc` stable during stall; no duplicate or skipped address.
- `desvio_valido` with alvo=32'h0000_0103 during BUSCA, ack 2 cycles later -> stale word never presented; next request at 32'h0000_0100.
- `desvio_valido` in ENTREGA with `instr_pronta`=1, alvo=32'h40 -> `instr_valida`=0 that cycle, next request at 32'h40.
- Redirect to 32'hFFFF_FFFC -> following sequential fetch at 32'h0000_0000.
- Assert `reset` while in DESCARTA -> all outputs to reset values immediately; fetch restarts at PC_RESET.
